sokoban_ctrl: RTL

SOKOBAN_CTRL -- requirements
Module: sokoban_ctrl

---
 rtl/game_pkg.sv | 7 +
 rtl/pos_step.sv | 26 ++
 rtl/sokoban_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared types and constants for the sokoban controller
package game_pkg;
  localparam int COORD_W = 12;
  localparam int STEP_DEFAULT = 20;
  typedef enum logic [1:0] {UP, DOWN, LEFT, RIGHT} dir_t;
  typedef enum logic [2:0] {IDLE, ARM, PROBE_MAN, PROBE_BOX, WIN} state_t;
endpackage

// File: rtl/pos_step.sv
// pos_step: one grid step of a sprite origin in a direction, flagging moves off the legal range
module pos_step import game_pkg::*; (
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [1:0]         dir,
  input  logic [COORD_W-1:0] step,
  output logic [COORD_W-1:0] nx,
  output logic [COORD_W-1:0] ny,
  output logic               underflow
);
  logic vert, neg;
  logic [COORD_W-1:0] c, n, lim;
  logic [COORD_W:0] sum;
  always_comb begin
    vert = dir == UP || dir == DOWN;
    neg = dir == UP || dir == LEFT;
    c = vert ? y : x;
    lim = {COORD_W{1'b1}} - step;
    sum = {1'b0, c} + {1'b0, step};
    n = neg ? c - step : sum[COORD_W-1:0];
    // Only the moved axis can leave the range [0, 4095 - step]
    underflow = neg ? c < step : sum > {1'b0, lim};
    nx = vert ? x : n;
    ny = vert ? n : y;
  end
endmodule

// File: rtl/sokoban_ctrl.sv
// sokoban_ctrl: key-driven player/box movement resolved by per-frame collision probes
module sokoban_ctrl import game_pkg::*; #(
  parameter int STEP   = STEP_DEFAULT,
  parameter int MAN_X0 = 320,
  parameter int MAN_Y0 = 260,
  parameter int BOX_X0 = 320,
  parameter int BOX_Y0 = 220
) (
  input  logic                pixelclk,
  input  logic                reset,
  input  logic                key_up,
  input  logic                key_down,
  input  logic                key_left,
  input  logic                key_right,
  input  logic                frame_end,
  input  logic                hit_wall,
  input  logic                hit_box,
  input  logic                hit_box_wall,
  input  logic                beat_level,
  output logic [COORD_W-1:0]  man_x,
  output logic [COORD_W-1:0]  man_y,
  output logic [COORD_W-1:0]  box_x,
  output logic [COORD_W-1:0]  box_y,
  output logic                busy,
  output logic                level_done,
  output logic [9:0]          move_count
);
  localparam logic [COORD_W-1:0] STEP_C = COORD_W'(STEP);
  localparam logic [COORD_W-1:0] MX0 = COORD_W'(MAN_X0);
  localparam logic [COORD_W-1:0] MY0 = COORD_W'(MAN_Y0);
  localparam logic [COORD_W-1:0] BX0 = COORD_W'(BOX_X0);
  localparam logic [COORD_W-1:0] BY0 = COORD_W'(BOX_Y0);

  state_t state_q, state_d;
  dir_t dir_q, dir_d;
  logic [COORD_W-1:0] man_x_q, man_x_d, man_y_q, man_y_d, box_x_q, box_x_d, box_y_q, box_y_d;
  logic [COORD_W-1:0] pm_x_q, pm_x_d, pm_y_q, pm_y_d, pb_x_q, pb_x_d, pb_y_q, pb_y_d;
  logic s_wall_q, s_wall_d, s_box_q, s_box_d, s_bwall_q, s_bwall_d, s_beat_q, s_beat_d;
  logic busy_q, busy_d, done_q, done_d;
  logic [9:0] cnt_q, cnt_d;
  logic [COORD_W-1:0] nmx, nmy, nbx, nby;
  logic m_uf, b_uf, wall, boxf, bwall, beat, clr, inc;

  pos_step u_man (.x(man_x_q), .y(man_y_q), .dir(dir_q), .step(STEP_C), .nx(nmx), .ny(nmy), .underflow(m_uf));
  pos_step u_box (.x(box_x_q), .y(box_y_q), .dir(dir_q), .step(STEP_C), .nx(nbx), .ny(nby), .underflow(b_uf));

  always_comb begin
    // Decisions include this cycle's flags so a hit coincident with frame_end belongs to the closing frame
    wall = s_wall_q | hit_wall;
    boxf = s_box_q | hit_box;
    bwall = s_bwall_q | hit_box_wall;
    beat = s_beat_q | beat_level;
    state_d = state_q;
    dir_d = dir_q;
    man_x_d = man_x_q;
    man_y_d = man_y_q;
    box_x_d = box_x_q;
    box_y_d = box_y_q;
    pm_x_d = pm_x_q;
    pm_y_d = pm_y_q;
    pb_x_d = pb_x_q;
    pb_y_d = pb_y_q;
    clr = 1'b0;
    inc = 1'b0;
    case (state_q)
      IDLE: if (key_up | key_down | key_left | key_right) begin
        dir_d = key_up ? UP : key_down ? DOWN : key_left ? LEFT : RIGHT;
        state_d = ARM;
      end
      ARM: if (frame_end) begin
        if (m_uf) state_d = IDLE;
        else begin
          pm_x_d = man_x_q;
          pm_y_d = man_y_q;
          pb_x_d = box_x_q;
          pb_y_d = box_y_q;
          man_x_d = nmx;
          man_y_d = nmy;
          clr = 1'b1;
          state_d = PROBE_MAN;
        end
      end
      PROBE_MAN: if (frame_end) begin
        if (wall || (boxf && b_uf)) begin
          man_x_d = pm_x_q;
          man_y_d = pm_y_q;
          state_d = IDLE;
        end else if (boxf) begin
          box_x_d = nbx;
          box_y_d = nby;
          clr = 1'b1;
          state_d = PROBE_BOX;
        end else begin
          inc = 1'b1;
          state_d = IDLE;
        end
      end
      PROBE_BOX: if (frame_end) begin
        if (bwall || wall) begin
          man_x_d = pm_x_q;
          man_y_d = pm_y_q;
          box_x_d = pb_x_q;
          box_y_d = pb_y_q;
          state_d = IDLE;
        end else begin
          inc = 1'b1;
          state_d = beat ? WIN : IDLE;
        end
      end
      default: state_d = state_q;
    endcase
    s_wall_d = clr ? 1'b0 : wall;
    s_box_d = clr ? 1'b0 : boxf;
    s_bwall_d = clr ? 1'b0 : bwall;
    s_beat_d = clr ? 1'b0 : beat;
    cnt_d = (inc && cnt_q != 10'h3ff) ? cnt_q + 10'd1 : cnt_q;
    busy_d = state_d != IDLE;
    done_d = state_d == WIN;
  end

  always_ff @(posedge pixelclk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      dir_q <= UP;
      man_x_q <= MX0;
      man_y_q <= MY0;
      box_x_q <= BX0;
      box_y_q <= BY0;
      pm_x_q <= MX0;
      pm_y_q <= MY0;
      pb_x_q <= BX0;
      pb_y_q <= BY0;
      s_wall_q <= 1'b0;
      s_box_q <= 1'b0;
      s_bwall_q <= 1'b0;
      s_beat_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      dir_q <= dir_d;
      man_x_q <= man_x_d;
      man_y_q <= man_y_d;
      box_x_q <= box_x_d;
      box_y_q <= box_y_d;
      pm_x_q <= pm_x_d;
      pm_y_q <= pm_y_d;
      pb_x_q <= pb_x_d;
      pb_y_q <= pb_y_d;
      s_wall_q <= s_wall_d;
      s_box_q <= s_box_d;
      s_bwall_q <= s_bwall_d;
      s_beat_q <= s_beat_d;
      busy_q <= busy_d;
      done_q <= done_d;
      cnt_q <= cnt_d;
    end

  assign man_x = man_x_q;
  assign man_y = man_y_q;
  assign box_x = box_x_q;
  assign box_y = box_y_q;
  assign busy = busy_q;
  assign level_done = done_q;
  assign move_count = cnt_q;
endmodule
